// File: rtl/totient_seq_ctrl.sv
// Euler-totient sweep sequencer: iterates n over 1..N_MAX, computes phi(n)
// by counting k with gcd(k,n)==1 (subtractive Euclid) and drives the hex
// digit of the result onto active-high ABCDEFG segment pins.
module totient_seq_ctrl #(
  parameter int unsigned N_MAX = 16,
  parameter int unsigned DWELL = 4,
  parameter int unsigned NW    = 5
) (
  input  logic          clk_0,
  input  logic          R,
  input  logic          run,
  input  logic          step,
  output logic [NW-1:0] n_out,
  output logic [3:0]    phi_out,
  output logic          valid,
  output logic          seq_end,
  output logic          A,
  output logic          B,
  output logic          C,
  output logic          D,
  output logic          E,
  output logic          F,
  output logic          G
);

  localparam int unsigned DW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {LOAD, GCD, NEXT_K, SHOW} state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   n_q, n_d, k_q, k_d, a_q, a_d, b_q, b_d;
  logic [3:0]      count_q, count_d, phi_q, phi_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [6:0]      seg_q, seg_d;
  logic            valid_q, valid_d, seq_end_q, seq_end_d;
  logic            advance;

  // Hex digit to ABCDEFG pattern (bit 6 = segment A)
  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    case (h)
      4'h0: seg_decode = 7'b1111110;
      4'h1: seg_decode = 7'b0110000;
      4'h2: seg_decode = 7'b1101101;
      4'h3: seg_decode = 7'b1111001;
      4'h4: seg_decode = 7'b0110011;
      4'h5: seg_decode = 7'b1011011;
      4'h6: seg_decode = 7'b1011111;
      4'h7: seg_decode = 7'b1110000;
      4'h8: seg_decode = 7'b1111111;
      4'h9: seg_decode = 7'b1111011;
      4'hA: seg_decode = 7'b1110111;
      4'hB: seg_decode = 7'b0011111;
      4'hC: seg_decode = 7'b1001110;
      4'hD: seg_decode = 7'b0111101;
      4'hE: seg_decode = 7'b1001111;
      default: seg_decode = 7'b1000111;
    endcase
  endfunction

  // Next-state and datapath update for the LOAD/GCD/NEXT_K/SHOW loop
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    count_d   = count_q;
    phi_d     = phi_q;
    dwell_d   = dwell_q;
    seg_d     = seg_q;
    valid_d   = valid_q;
    seq_end_d = 1'b0;
    advance   = 1'b0;
    case (state_q)
      LOAD: begin
        a_d     = k_q;
        b_d     = n_q;
        state_d = GCD;
      end
      GCD: begin
        if (a_q == b_q) begin
          if (a_q == NW'(1)) count_d = count_q + 4'd1;
          state_d = NEXT_K;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      NEXT_K: begin
        if (k_q == n_q) begin
          phi_d   = count_q;
          seg_d   = seg_decode(count_q);
          valid_d = 1'b1;
          dwell_d = '0;
          state_d = SHOW;
        end else begin
          k_d     = k_q + NW'(1);
          state_d = LOAD;
        end
      end
      SHOW: begin
        // run dominates step; with run low the dwell timer is held cleared
        if (run) begin
          if (dwell_q == DW'(DWELL - 1)) advance = 1'b1;
          else dwell_d = dwell_q + DW'(1);
        end else begin
          dwell_d = '0;
          advance = step;
        end
        if (advance) begin
          n_d       = (n_q == NW'(N_MAX)) ? NW'(1) : n_q + NW'(1);
          seq_end_d = (n_q == NW'(N_MAX));
          valid_d   = 1'b0;
          k_d       = NW'(1);
          count_d   = '0;
          state_d   = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_0) begin
    if (!R) begin
      state_q   <= LOAD;
      n_q       <= NW'(1);
      k_q       <= NW'(1);
      a_q       <= NW'(1);
      b_q       <= NW'(1);
      count_q   <= '0;
      phi_q     <= 4'd1;
      dwell_q   <= '0;
      seg_q     <= 7'b0110000;
      valid_q   <= 1'b0;
      seq_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      count_q   <= count_d;
      phi_q     <= phi_d;
      dwell_q   <= dwell_d;
      seg_q     <= seg_d;
      valid_q   <= valid_d;
      seq_end_q <= seq_end_d;
    end
  end

  assign n_out   = n_q;
  assign phi_out = phi_q;
  assign valid   = valid_q;
  assign seq_end = seq_end_q;
  assign {A, B, C, D, E, F, G} = seg_q;

endmodule

// File: tb/tb_totient_seq_ctrl.sv
// Directed bench for totient_seq_ctrl: reset, full sweep, step mode,
// mid-computation reset and run/step interaction.
module tb_totient_seq_ctrl;

  logic       clk_0 = 1'b0;
  logic       R = 1'b0;
  logic       run = 1'b1;
  logic       step = 1'b0;
  logic [4:0] n_out;
  logic [3:0] phi_out;
  logic       valid, seq_end;
  logic       A, B, C, D, E, F, G;
  logic [6:0] seg;

  int total = 0;
  int bad = 0;
  int seq_cnt = 0;

  logic [3:0] phi_exp [16] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd2, 4'd6, 4'd4,
                               4'd6, 4'd4, 4'd10, 4'd4, 4'd12, 4'd6, 4'd8, 4'd8};
  logic [6:0] seg_tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  assign seg = {A, B, C, D, E, F, G};

  always #5 clk_0 = ~clk_0;

  totient_seq_ctrl #(.N_MAX(16), .DWELL(4), .NW(5)) dut (
    .clk_0(clk_0), .R(R), .run(run), .step(step),
    .n_out(n_out), .phi_out(phi_out), .valid(valid), .seq_end(seq_end),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G)
  );

  // One rising edge, then sample on the falling edge
  task automatic tick;
    @(negedge clk_0);
    if (seq_end === 1'b1) seq_cnt++;
  endtask

  task automatic wait_valid(input logic lvl, input int max, output bit ok);
    for (int i = 0; i < max && valid !== lvl; i++) tick();
    ok = (valid === lvl);
  endtask

  task automatic test_reset;
    R = 1'b0; run = 1'b1; step = 1'b0;
    tick(); tick();
    total++; if (n_out !== 5'd1) begin bad++; $display("FAIL reset_n got=%0d exp=1", n_out); end
    total++; if (phi_out !== 4'd1) begin bad++; $display("FAIL reset_phi got=%0d exp=1", phi_out); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (seq_end !== 1'b0) begin bad++; $display("FAIL reset_seq_end got=%b exp=0", seq_end); end
    total++; if (seg !== 7'b0110000) begin bad++; $display("FAIL reset_seg got=%b exp=0110000", seg); end
  endtask

  task automatic test_sweep;
    bit ok;
    int hold;
    seq_cnt = 0;
    R = 1'b1; run = 1'b1;
    tick(); tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL phi1_early got=%b exp=0", valid); end
    tick();
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL phi1_latency got=%b exp=1", valid); end
    for (int n = 1; n <= 16; n++) begin
      wait_valid(1'b1, 600, ok);
      total++; if (!ok) begin bad++; $display("FAIL sweep_timeout n=%0d got=no_valid exp=valid", n); end
      total++; if (n_out !== 5'(n)) begin bad++; $display("FAIL sweep_n got=%0d exp=%0d", n_out, n); end
      total++; if (phi_out !== phi_exp[n-1]) begin bad++; $display("FAIL sweep_phi n=%0d got=%0d exp=%0d", n, phi_out, phi_exp[n-1]); end
      total++; if (seg !== seg_tbl[phi_exp[n-1]]) begin bad++; $display("FAIL sweep_seg n=%0d got=%b exp=%b", n, seg, seg_tbl[phi_exp[n-1]]); end
      if (n == 11) begin
        total++; if (seg !== 7'b1110111) begin bad++; $display("FAIL seg_n11 got=%b exp=1110111", seg); end
      end
      if (n == 13) begin
        total++; if (seg !== 7'b1001110) begin bad++; $display("FAIL seg_n13 got=%b exp=1001110", seg); end
      end
      hold = 0;
      while (valid === 1'b1 && hold < 50) begin hold++; tick(); end
      total++; if (hold !== 4) begin bad++; $display("FAIL sweep_dwell n=%0d got=%0d exp=4", n, hold); end
      total++; if (seq_end !== (n == 16)) begin bad++; $display("FAIL sweep_seq_end n=%0d got=%b exp=%b", n, seq_end, n == 16); end
      total++; if (n_out !== 5'((n == 16) ? 1 : n + 1)) begin bad++; $display("FAIL sweep_next_n n=%0d got=%0d", n, n_out); end
    end
    tick();
    total++; if (seq_end !== 1'b0) begin bad++; $display("FAIL seq_end_width got=%b exp=0", seq_end); end
    total++; if (seq_cnt !== 1) begin bad++; $display("FAIL seq_end_count got=%0d exp=1", seq_cnt); end
    wait_valid(1'b1, 600, ok);
    total++; if (!ok || phi_out !== 4'd1 || n_out !== 5'd1) begin bad++; $display("FAIL wrap_phi1 got n=%0d phi=%0d exp n=1 phi=1", n_out, phi_out); end
  endtask

  task automatic test_step_mode;
    bit ok;
    R = 1'b0; run = 1'b0; step = 1'b0;
    tick();
    R = 1'b1; step = 1'b1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL step_busy_valid got=%b exp=0", valid); end
    tick();
    step = 1'b0;
    wait_valid(1'b1, 100, ok);
    total++; if (!ok || n_out !== 5'd1 || phi_out !== 4'd1) begin bad++; $display("FAIL step_ignored got n=%0d phi=%0d exp n=1 phi=1", n_out, phi_out); end
    for (int i = 0; i < 10; i++) tick();
    total++; if (n_out !== 5'd1 || valid !== 1'b1) begin bad++; $display("FAIL step_hold got n=%0d valid=%b exp n=1 valid=1", n_out, valid); end
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; tick(); step = 1'b0;
      total++; if (n_out !== 5'(i + 2) || valid !== 1'b0) begin bad++; $display("FAIL step_adv got n=%0d valid=%b exp n=%0d valid=0", n_out, valid, i + 2); end
      wait_valid(1'b1, 200, ok);
      total++; if (!ok || phi_out !== phi_exp[i+1]) begin bad++; $display("FAIL step_phi n=%0d got=%0d exp=%0d", i + 2, phi_out, phi_exp[i+1]); end
    end
  endtask

  task automatic test_mid_reset;
    int guard;
    run = 1'b1;
    guard = 0;
    while (!(n_out === 5'd13 && valid === 1'b0) && guard < 5000) begin guard++; tick(); end
    total++; if (n_out !== 5'd13) begin bad++; $display("FAIL mid_reach_n13 got=%0d exp=13", n_out); end
    tick(); tick(); tick();
    R = 1'b0;
    tick();
    R = 1'b1;
    total++; if (n_out !== 5'd1 || valid !== 1'b0) begin bad++; $display("FAIL mid_reset got n=%0d valid=%b exp n=1 valid=0", n_out, valid); end
    total++; if (seg !== 7'b0110000 || phi_out !== 4'd1) begin bad++; $display("FAIL mid_reset_seg got seg=%b phi=%0d exp 0110000/1", seg, phi_out); end
    tick(); tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_early got=%b exp=0", valid); end
    tick();
    total++; if (valid !== 1'b1 || phi_out !== 4'd1) begin bad++; $display("FAIL mid_phi1 got valid=%b phi=%0d exp 1/1", valid, phi_out); end
  endtask

  task automatic test_run_step_mix;
    bit ok;
    int hold;
    step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (n_out !== 5'd1 || valid !== 1'b1) begin bad++; $display("FAIL mix_early_adv got n=%0d valid=%b exp n=1 valid=1", n_out, valid); end
    end
    step = 1'b0;
    tick();
    total++; if (n_out !== 5'd2 || valid !== 1'b0) begin bad++; $display("FAIL mix_dwell_adv got n=%0d valid=%b exp n=2 valid=0", n_out, valid); end
    wait_valid(1'b1, 200, ok);
    run = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    total++; if (!ok || n_out !== 5'd2 || valid !== 1'b1) begin bad++; $display("FAIL mix_freeze got n=%0d valid=%b exp n=2 valid=1", n_out, valid); end
    step = 1'b1; tick(); step = 1'b0;
    total++; if (n_out !== 5'd3 || valid !== 1'b0) begin bad++; $display("FAIL mix_step got n=%0d valid=%b exp n=3 valid=0", n_out, valid); end
    wait_valid(1'b1, 200, ok);
    run = 1'b1;
    tick(); tick();
    run = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (!ok || n_out !== 5'd3 || valid !== 1'b1) begin bad++; $display("FAIL mix_drop_run got n=%0d valid=%b exp n=3 valid=1", n_out, valid); end
    run = 1'b1;
    hold = 0;
    while (valid === 1'b1 && hold < 50) begin hold++; tick(); end
    total++; if (hold !== 4) begin bad++; $display("FAIL mix_dwell_cleared got=%0d exp=4", hold); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_step_mode();
    test_mid_reset();
    test_run_step_mix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
